// File: rtl/main_ctrl_fsm.sv
// Sequenced main control for the single-cycle datapath: boot hold, two-cycle loads, halt/illegal trap.
// Optional load-wait counter built only when CTRL_PERF_CNT_EN is defined.
module main_ctrl_fsm #(
   parameter int BOOT_CYCLES = 2,
   parameter int RETIRE_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          OpCode,
   output logic                RegDst,
   output logic                AluSrc,
   output logic                MemtoReg,
   output logic                RegWrite,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                Branch,
   output logic                Jump,
   output logic [3:0]          ALUOp,
   output logic                PCWrite,
   output logic                Halted,
   output logic                IllegalOp,
   output logic [RETIRE_W-1:0] RetireCount,
   output logic [RETIRE_W-1:0] StallCount
);

   localparam logic [1:0] ST_BOOT    = 2'd0;
   localparam logic [1:0] ST_EXEC    = 2'd1;
   localparam logic [1:0] ST_LOAD_WB = 2'd2;
   localparam logic [1:0] ST_HALT    = 2'd3;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

   logic [1:0] state;
   logic [1:0] next_state;
   logic [3:0] boot_cnt;
   logic       set_halt;
   logic       set_illegal;

   always_comb begin
      RegDst      = 1'b0;
      AluSrc      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      Branch      = 1'b0;
      Jump        = 1'b0;
      ALUOp       = 4'b0000;
      PCWrite     = 1'b0;
      next_state  = state;
      set_halt    = 1'b0;
      set_illegal = 1'b0;
      case (state)
         ST_BOOT: begin
            if (boot_cnt == BOOT_LAST) next_state = ST_EXEC;
         end
         ST_EXEC: begin
            PCWrite = 1'b1;
            case (OpCode)
               OP_RTYPE: begin RegDst = 1'b1; RegWrite = 1'b1; ALUOp = 4'b0010; end
               OP_LW: begin
                  // PC held so the synchronous read data is ready next cycle.
                  AluSrc     = 1'b1;
                  MemRead    = 1'b1;
                  PCWrite    = 1'b0;
                  next_state = ST_LOAD_WB;
               end
               OP_SW:   begin AluSrc = 1'b1; MemWrite = 1'b1; end
               OP_BEQ:  begin Branch = 1'b1; ALUOp = 4'b0001; end
               OP_J:    Jump = 1'b1;
               OP_ADDI: begin AluSrc = 1'b1; RegWrite = 1'b1; end
               OP_ANDI: begin AluSrc = 1'b1; RegWrite = 1'b1; ALUOp = 4'b0011; end
               OP_ORI:  begin AluSrc = 1'b1; RegWrite = 1'b1; ALUOp = 4'b0100; end
               OP_SLTI: begin AluSrc = 1'b1; RegWrite = 1'b1; ALUOp = 4'b0101; end
               OP_HALT: begin
                  PCWrite    = 1'b0;
                  next_state = ST_HALT;
                  set_halt   = 1'b1;
               end
               default: begin
                  PCWrite     = 1'b0;
                  next_state  = ST_HALT;
                  set_halt    = 1'b1;
                  set_illegal = 1'b1;
               end
            endcase
         end
         ST_LOAD_WB: begin
            AluSrc     = 1'b1;
            MemRead    = 1'b1;
            MemtoReg   = 1'b1;
            RegWrite   = 1'b1;
            PCWrite    = 1'b1;
            next_state = ST_EXEC;
         end
         default: ;
      endcase
      if (reset) begin
         RegDst   = 1'b0;
         AluSrc   = 1'b0;
         MemtoReg = 1'b0;
         RegWrite = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         Branch   = 1'b0;
         Jump     = 1'b0;
         ALUOp    = 4'b0000;
         PCWrite  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_BOOT;
         boot_cnt    <= 4'd0;
         RetireCount <= '0;
         Halted      <= 1'b0;
         IllegalOp   <= 1'b0;
      end else begin
         state <= next_state;
         if (state == ST_BOOT) boot_cnt <= boot_cnt + 4'd1;
         if (PCWrite) RetireCount <= RetireCount + RETIRE_W'(1);
         if (set_halt) Halted <= 1'b1;
         if (set_illegal) IllegalOp <= 1'b1;
      end
   end

`ifdef CTRL_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) StallCount <= '0;
      else if (state == ST_EXEC && OpCode == OP_LW) StallCount <= StallCount + RETIRE_W'(1);
   end
`else
   assign StallCount = '0;
`endif

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Bench for main_ctrl_fsm: per-cycle expected outputs from an independent model go through exp_q.
// Counters run at RETIRE_W=4 so wrap-around is reached quickly.
module tb_main_ctrl_fsm;

   localparam int RW = 4;
   localparam int EW = 13 + 2 + 2 * RW;
   localparam int S_BOOT = 0, S_EXEC = 1, S_LOAD = 2, S_HALT = 3;

   logic          clk;
   logic          reset;
   logic [5:0]    OpCode;
   logic          RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump;
   logic [3:0]    ALUOp;
   logic          PCWrite, Halted, IllegalOp;
   logic [RW-1:0] RetireCount, StallCount;

   main_ctrl_fsm #(.BOOT_CYCLES(2), .RETIRE_W(RW)) dut (
      .clk(clk), .reset(reset), .OpCode(OpCode),
      .RegDst(RegDst), .AluSrc(AluSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump),
      .ALUOp(ALUOp), .PCWrite(PCWrite), .Halted(Halted), .IllegalOp(IllegalOp),
      .RetireCount(RetireCount), .StallCount(StallCount)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic [EW-1:0] exp_q[$];

   int            m_state;
   int            m_boot;
   logic          m_halted, m_illegal;
   logic [RW-1:0] m_retire, m_stall;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // bits: reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch jump alu_op[3:0] pc_write
   function automatic logic [12:0] model_ctrl(input int st, input logic [5:0] op, input logic rst);
      logic [12:0] v;
      v = 13'd0;
      if (rst) return v;
      if (st == S_LOAD) return 13'b0_1_1_1_1_0_0_0_0000_1;
      if (st != S_EXEC) return v;
      case (op)
         6'b000000: v = 13'b1_0_0_1_0_0_0_0_0010_1;
         6'b100011: v = 13'b0_1_0_0_1_0_0_0_0000_0;
         6'b101011: v = 13'b0_1_0_0_0_1_0_0_0000_1;
         6'b000100: v = 13'b0_0_0_0_0_0_1_0_0001_1;
         6'b000010: v = 13'b0_0_0_0_0_0_0_1_0000_1;
         6'b001000: v = 13'b0_1_0_1_0_0_0_0_0000_1;
         6'b001100: v = 13'b0_1_0_1_0_0_0_0_0011_1;
         6'b001101: v = 13'b0_1_0_1_0_0_0_0_0100_1;
         6'b001010: v = 13'b0_1_0_1_0_0_0_0_0101_1;
         default:   v = 13'd0;
      endcase
      return v;
   endfunction

   task automatic model_reset();
      m_state   = S_BOOT;
      m_boot    = 0;
      m_halted  = 1'b0;
      m_illegal = 1'b0;
      m_retire  = '0;
      m_stall   = '0;
   endtask

   // driver: one cycle of stimulus, expected pushed, DUT sampled after settling, model advanced
   task automatic step(input logic rst, input logic [5:0] op);
      logic [12:0]   c;
      logic [EW-1:0] got, e;
      @(negedge clk);
      reset  = rst;
      OpCode = op;
      c = model_ctrl(m_state, op, rst);
      exp_q.push_back({c, m_halted, m_illegal, m_retire, m_stall});
      #1;
      got = {RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp, PCWrite,
             Halted, IllegalOp, RetireCount, StallCount};
      e = exp_q.pop_front();
      check("ctrl",     32'(got[EW-1:EW-12]), 32'(e[EW-1:EW-12]));
      check("pcwrite",  32'(got[EW-13]),      32'(e[EW-13]));
      check("halted",   32'(got[2*RW+1]),     32'(e[2*RW+1]));
      check("illegal",  32'(got[2*RW]),       32'(e[2*RW]));
      check("retire",   32'(got[2*RW-1:RW]),  32'(e[2*RW-1:RW]));
      check("stall",    32'(got[RW-1:0]),     32'(e[RW-1:0]));
      if (rst) begin
         model_reset();
      end else begin
         if (c[0]) m_retire = m_retire + 1'b1;
`ifdef CTRL_PERF_CNT_EN
         if (m_state == S_EXEC && op == 6'b100011) m_stall = m_stall + 1'b1;
`endif
         case (m_state)
            S_BOOT: begin
               if (m_boot == 1) m_state = S_EXEC;
               m_boot++;
            end
            S_EXEC: begin
               if (op == 6'b100011) m_state = S_LOAD;
               else if (!c[0]) begin
                  m_state  = S_HALT;
                  m_halted = 1'b1;
                  if (op != 6'b111111) m_illegal = 1'b1;
               end
            end
            S_LOAD: m_state = S_EXEC;
            default: ;
         endcase
      end
   endtask

   logic [5:0] legal_ops [9];

   initial begin
      legal_ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                    6'b001000, 6'b001100, 6'b001101, 6'b001010};
      reset  = 1'b1;
      OpCode = 6'b000000;
      @(posedge clk);
      model_reset();
      step(1'b1, 6'b000000);
      step(1'b1, 6'b100011);
      // boot hold, then R-type and ori
      step(1'b0, 6'b000000);
      step(1'b0, 6'b000000);
      step(1'b0, 6'b000000);
      step(1'b0, 6'b001101);
      // load held across its wait cycle
      step(1'b0, 6'b100011);
      step(1'b0, 6'b100011);
      foreach (legal_ops[i]) if (i >= 2) step(1'b0, legal_ops[i]);
      for (int i = 0; i < 12; i++) step(1'b0, legal_ops[$urandom_range(0, 8)]);
      // halt is sticky until reset
      step(1'b0, 6'b111111);
      step(1'b0, 6'b000000);
      step(1'b0, 6'b000000);
      step(1'b0, 6'b100011);
      // reset from HALT, then illegal opcode
      step(1'b1, 6'b000000);
      step(1'b1, 6'b000000);
      step(1'b0, 6'b000000);
      step(1'b0, 6'b000000);
      step(1'b0, 6'b010101);
      step(1'b0, 6'b000000);
      step(1'b0, 6'b000000);
      // reset mid-load abandons it
      step(1'b1, 6'b000000);
      step(1'b0, 6'b000000);
      step(1'b0, 6'b000000);
      step(1'b0, 6'b100011);
      step(1'b1, 6'b100011);
      step(1'b0, 6'b000000);
      step(1'b0, 6'b000000);
      // counter wrap with 17+ retirements
      for (int i = 0; i < 19; i++) step(1'b0, 6'b000000);
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 6'b100011);
         step(1'b0, 6'b100011);
      end
      step(1'b0, 6'b000000);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
